// File: rtl/mmio_arbiter_pkg.sv
// Shared definitions for the MMIO data-port arbiter: FSM states, grant codes
// and the read value returned on a timeout completion.
package mmio_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic [1:0]  GNT_NONE    = 2'b00;
    localparam logic [1:0]  GNT_C       = 2'b01;
    localparam logic [1:0]  GNT_D       = 2'b10;

    localparam logic [31:0] ARB_TO_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mmio_arbiter_arb_pick.sv
// Winner selection for the MMIO arbiter: CPU has fixed priority unless the
// DMA starvation counter has reached STARVE_LIMIT.
module arb_pick #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic c_req,
    input  logic d_req,
    input  logic take,
    output logic win_d,
    output logic win_c
);

    localparam int unsigned     CW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        win_d = d_req & (~c_req | (cnt_q == LIM));
        win_c = c_req & ~win_d;
        cnt_d = cnt_q;
        // Counts only losses while D is actually waiting; saturates because D wins at LIM.
        if (take) begin
            if (win_d) begin
                cnt_d = '0;
            end else if (d_req && (cnt_q != LIM)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Arbitrates the single MMIO data port between the CPU M-stage (C) and DMA (D).
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_byteen,
    output logic        c_ack,
    output logic [31:0] c_rdata,
    output logic        cpu_stall,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteen,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        b_req,
    output logic [31:0] b_addr,
    output logic [31:0] b_wdata,
    output logic [3:0]  b_byteen,
    input  logic        b_ack,
    input  logic [31:0] b_rdata,
    output logic [1:0]  grant,
    output logic        err
);

    arb_state_e  state_q;
    logic [1:0]  grant_q;
    logic [31:0] b_addr_q;
    logic [31:0] b_wdata_q;
    logic [3:0]  b_byteen_q;

    logic        take;
    logic        win_c;
    logic        win_d;
    logic        to_hit;
    logic        done;
    logic [31:0] rd_val;

    assign take = (state_q == ARB_IDLE) & (c_req | d_req);

    arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk   (clk),
        .reset (reset),
        .c_req (c_req),
        .d_req (d_req),
        .take  (take),
        .win_d (win_d),
        .win_c (win_c)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] to_q;

    // Held at zero in IDLE so it starts from zero on every BUSY entry.
    always_ff @(posedge clk) begin
        if (reset || (state_q == ARB_IDLE)) begin
            to_q <= '0;
        end else if (to_q != TO_LIM) begin
            to_q <= to_q + 1'b1;
        end
    end

    assign to_hit = (state_q == ARB_BUSY) & (to_q == TO_LIM) & ~b_ack;
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_q    <= GNT_NONE;
            b_addr_q   <= '0;
            b_wdata_q  <= '0;
            b_byteen_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (win_d) begin
                        state_q    <= ARB_BUSY;
                        grant_q    <= GNT_D;
                        b_addr_q   <= d_addr;
                        b_wdata_q  <= d_wdata;
                        b_byteen_q <= d_byteen;
                    end else if (win_c) begin
                        state_q    <= ARB_BUSY;
                        grant_q    <= GNT_C;
                        b_addr_q   <= c_addr;
                        b_wdata_q  <= c_wdata;
                        b_byteen_q <= c_byteen;
                    end
                end
                ARB_BUSY: begin
                    if (b_ack || to_hit) begin
                        state_q <= ARB_IDLE;
                        grant_q <= GNT_NONE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= GNT_NONE;
                end
            endcase
        end
    end

    // Completion is gated by reset so an abandoned transaction never acks.
    assign done   = (state_q == ARB_BUSY) & (b_ack | to_hit) & ~reset;
    assign rd_val = to_hit ? ARB_TO_DATA : b_rdata;

    assign c_ack     = done & (grant_q == GNT_C);
    assign d_ack     = done & (grant_q == GNT_D);
    assign c_rdata   = c_ack ? rd_val : '0;
    assign d_rdata   = d_ack ? rd_val : '0;
    assign err       = done & to_hit;
    assign cpu_stall = c_req & ~c_ack & ~reset;

    assign b_req    = (state_q == ARB_BUSY);
    assign b_addr   = b_addr_q;
    assign b_wdata  = b_wdata_q;
    assign b_byteen = b_byteen_q;
    assign grant    = grant_q;

endmodule

// File: doc/mmio_arbiter.md
Name: mmio_arbiter

Overview:
- Shares the single memory-mapped data port (DM, TC1, TC2 and the interrupt window, decoded downstream by the bridge) between two requesters: the CPU M-stage load/store unit (C) and a DMA engine (D).
- Sits between the pipeline M-stage / DMA and the bridge.
- Serialises transactions, holds each grant until the slave acknowledges, and stalls the CPU while its access is pending.
- The CPU has fixed priority, subject to a DMA anti-starvation limit.

Parameters:
- STARVE_LIMIT, 4: consecutive arbitration losses by D, while D is requesting, before D is forced to win.
- TIMEOUT_CYCLES, 64: maximum BUSY cycles before a forced completion. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- c_req  in  1  CPU request; held with its payload until c_ack
- c_addr  in  32  CPU byte address
- c_wdata  in  32  CPU write data
- c_byteen  in  4  CPU byte enables; 0 means read
- c_ack  out  1  CPU completion pulse
- c_rdata  out  32  CPU read data; valid while c_ack=1
- cpu_stall  out  1  c_req & ~c_ack; freezes the pipeline
- d_req, d_addr, d_wdata, d_byteen, d_ack, d_rdata  same as the CPU port, for the DMA requester
- b_req  out  1  transaction to the bridge
- b_addr  out  32  latched address
- b_wdata  out  32  latched write data
- b_byteen  out  4  latched byte enables
- b_ack  in  1  slave done
- b_rdata  in  32  slave read data; valid with b_ack
- grant  out  2  01 = C owns the port, 10 = D owns the port, 00 = idle
- err  out  1  timeout completion flag; valid with the ack

Behaviour:
Reset:
- state=IDLE; b_req, c_ack, d_ack, err = 0; grant=00.
- b_addr, b_wdata, b_byteen = 0; starvation counter = 0.

IDLE:
- If c_req or d_req is high, pick a winner.
- D wins if d_req & (~c_req | cnt==STARVE_LIMIT); otherwise C wins.
- Latch the winner's addr, wdata and byteen into the b_* registers; set grant; go to BUSY.
- b_req=1 from the next cycle.
- Counter: increment when C wins while d_req=1. Clear whenever D wins. Saturates at STARVE_LIMIT.

BUSY:
- b_req stays 1 and the b_* outputs stay stable.
- On b_ack=1:
  - the owner's ack is high in that same cycle (combinational from b_ack & grant);
  - the owner's rdata = b_rdata; the other requester's rdata = 0;
  - next state is IDLE, grant=00, b_req=0.
- Minimum latency, request to ack: 2 cycles (single-cycle slave).
- Throughput: at most one transaction per 2 cycles, because an IDLE cycle always separates grants.

Boundary conditions:
- b_ack in IDLE is ignored.
- Owner drops req mid-BUSY (a protocol violation): the transaction still completes and the ack is still pulsed.
- Non-owner changes its payload during BUSY: no effect.
- C and D request simultaneously at cnt<STARVE_LIMIT: C wins.
- Reset during BUSY: the transaction is abandoned, b_req=0 on the next edge, and no ack is issued.
- A requester whose req stays high after its ack starts a new transaction; C therefore re-wins at the next IDLE unless the counter forces D.
- cpu_stall is purely combinational and is 0 while reset is high.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A BUSY cycle counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entry to BUSY.
  - If it reaches TIMEOUT_CYCLES without b_ack, the owner's ack is pulsed with rdata=32'hDEAD_BEEF and err=1 for that cycle.
  - The state returns to IDLE.
  - A late b_ack arriving afterwards in IDLE is ignored.
- Undefined: there is no counter, err is tied to 0, and BUSY waits indefinitely.

Decomposition:
- Shared header define.v gains:
  - state encodings ARB_IDLE=1'b0, ARB_BUSY=1'b1;
  - grant codes GNT_NONE=2'b00, GNT_C=2'b01, GNT_D=2'b10;
  - the timeout read value ARB_TO_DATA=32'hDEAD_BEEF.
- One sub-module, arb_pick: combinational winner selection plus the registered starvation counter (clk, reset, c_req, d_req, take → win_d, win_c).

Test Plan:
- C read alone: addr 0x0000_0100, byteen 0, slave acks 1 cycle after b_req with 0x1234_5678 → c_ack in cycle 2, c_rdata=0x1234_5678, cpu_stall high only in cycles 0–1.
- C write: addr 0x7F04, byteen 4'b1111, wdata 0xAABB_CCDD, slave delay 3 → b_* outputs stable all 3 BUSY cycles, one c_ack, d_ack stays 0.
- C and D request continuously with STARVE_LIMIT=4 → grant sequence C,C,C,C,D,C,C,C,C,D…; D is never starved.
- Reset asserted in the 2nd BUSY cycle of a D transaction → b_req=0 and grant=00 next cycle, no d_ack; after reset, a C request is served normally.
- b_ack pulsed while IDLE with no requests → no ack, state stays IDLE.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks → c_ack=1, err=1, c_rdata=0xDEAD_BEEF exactly 8 cycles after BUSY entry. Without the macro, the same stimulus leaves cpu_stall high indefinitely.
